// File: rtl/rvm_adder_result_buffer.sv
// Two-entry skid buffer behind the 32-bit add/sub unit: registers each result
// with its tag and the compare/status flags derived at capture time.
module rvm_adder_result_buffer #(
    parameter int         TAG_W  = 5,
    parameter logic [2:0] OP_ADD = 3'd1,
    parameter logic [2:0] OP_SUB = 3'd2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_lhs_msb,
    input  logic             in_rhs_msb,
    input  logic [32:0]      in_result,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_lt,
    output logic             out_ltu
);

    typedef struct packed {
        logic [31:0]      result;
        logic [TAG_W-1:0] tag;
        logic             zero;
        logic             neg;
        logic             carry;
        logic             ovf;
        logic             lt;
        logic             ltu;
    } entry_t;

    entry_t     slot [2];
    entry_t     new_entry;
    entry_t     head;
    logic [1:0] count;
    logic       wr_ptr;
    logic       rd_ptr;
    logic       push;
    logic       pop;
    logic       ovf_add;
    logic       ovf_sub;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign ovf_add = (in_lhs_msb == in_rhs_msb) && (in_result[31] != in_lhs_msb);
    assign ovf_sub = (in_lhs_msb != in_rhs_msb) && (in_result[31] != in_lhs_msb);

    // Unknown op codes still store the result but carry no flags at all.
    always_comb begin
        new_entry        = '0;
        new_entry.result = in_result[31:0];
        new_entry.tag    = in_tag;
        if (in_op == OP_ADD || in_op == OP_SUB) begin
            new_entry.zero  = (in_result[31:0] == 32'd0);
            new_entry.neg   = in_result[31];
            new_entry.carry = in_result[32];
        end
        if (in_op == OP_ADD) begin
            new_entry.ovf = ovf_add;
        end else if (in_op == OP_SUB) begin
            new_entry.ovf = ovf_sub;
            new_entry.lt  = in_result[31] ^ ovf_sub;
            new_entry.ltu = in_result[32];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) slot[i] <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= new_entry;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head       = slot[rd_ptr];
    assign out_result = head.result;
    assign out_tag    = head.tag;
    assign out_zero   = head.zero;
    assign out_neg    = head.neg;
    assign out_carry  = head.carry;
    assign out_ovf    = head.ovf;
    assign out_lt     = head.lt;
    assign out_ltu    = head.ltu;

endmodule

// File: tb/tb_rvm_adder_result_buffer.sv
// Directed bench for rvm_adder_result_buffer: flag table streamed back-to-back,
// then reset, streaming, backpressure, flush and mid-fill reset sequences.
module tb_rvm_adder_result_buffer;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             resetn;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic             in_lhs_msb;
    logic             in_rhs_msb;
    logic [32:0]      in_result;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero, out_neg, out_carry, out_ovf, out_lt, out_ltu;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rvm_adder_result_buffer #(.TAG_W(TAG_W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_lhs_msb(in_lhs_msb), .in_rhs_msb(in_rhs_msb),
        .in_result(in_result), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry),
        .out_ovf(out_ovf), .out_lt(out_lt), .out_ltu(out_ltu)
    );

    typedef struct {
        logic [2:0]  op;
        logic        a;
        logic        b;
        logic [32:0] res;
        logic [31:0] exp_res;
        logic [5:0]  exp_flags;   // {zero, neg, carry, ovf, lt, ltu}
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic a, input logic b,
                         input logic [32:0] res, input logic [TAG_W-1:0] tag);
        in_valid   = v;
        in_op      = op;
        in_lhs_msb = a;
        in_rhs_msb = b;
        in_result  = res;
        in_tag     = tag;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 1'b0, 1'b0, 33'd0, '0);
    endtask

    function automatic logic [5:0] flags();
        return {out_zero, out_neg, out_carry, out_ovf, out_lt, out_ltu};
    endfunction

    initial begin
        vecs[0] = '{3'd1, 1'b0, 1'b0, 33'h0_8000_0000, 32'h8000_0000, 6'b010100};
        vecs[1] = '{3'd2, 1'b0, 1'b0, 33'h1_FFFF_FFFF, 32'hFFFF_FFFF, 6'b011011};
        vecs[2] = '{3'd2, 1'b1, 1'b0, 33'h0_7FFF_FFFF, 32'h7FFF_FFFF, 6'b000110};
        vecs[3] = '{3'd2, 1'b0, 1'b0, 33'h0_0000_0000, 32'h0000_0000, 6'b100000};
        vecs[4] = '{3'd1, 1'b1, 1'b0, 33'h1_0000_0000, 32'h0000_0000, 6'b101000};
        vecs[5] = '{3'd1, 1'b1, 1'b1, 33'h1_0000_0000, 32'h0000_0000, 6'b101100};
        vecs[6] = '{3'd5, 1'b1, 1'b0, 33'h0_0000_1234, 32'h0000_1234, 6'b000000};
        vecs[7] = '{3'd2, 1'b0, 1'b1, 33'h1_8000_0000, 32'h8000_0000, 6'b011101};

        // Reset with garbage on the inputs: outputs must clear immediately.
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 3'd1, 1'b1, 1'b0, {1'b1, $urandom()}, 5'd17);
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_result", 64'(out_result), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        chk("rst_flags", 64'(flags()), 64'd0);
        @(negedge clk);
        idle();
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // Flag table, streamed one entry per cycle with out_ready high.
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                chk($sformatf("vec%0d_valid", i-1), 64'(out_valid), 64'd1);
                chk($sformatf("vec%0d_result", i-1), 64'(out_result), 64'(vecs[i-1].exp_res));
                chk($sformatf("vec%0d_tag", i-1), 64'(out_tag), 64'(i));
                chk($sformatf("vec%0d_flags", i-1), 64'(flags()), 64'(vecs[i-1].exp_flags));
            end
            if (i < 8) drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, 5'(i+1));
            else idle();
            @(negedge clk);
        end
        chk("table_drained", 64'(out_valid), 64'd0);

        // 16 back-to-back pushes: each emerges one cycle later, no bubbles.
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                chk($sformatf("stream%0d_valid", i-1), 64'(out_valid), 64'd1);
                chk($sformatf("stream%0d_tag", i-1), 64'(out_tag), 64'(i-1));
                chk($sformatf("stream%0d_result", i-1), 64'(out_result), 64'((i-1) * 32'h0101_0101));
            end
            chk($sformatf("stream%0d_in_ready", i), 64'(in_ready), 64'd1);
            if (i < 16) drive(1'b1, 3'd1, 1'b0, 1'b0, {1'b0, 32'(i * 32'h0101_0101)}, 5'(i));
            else idle();
            @(negedge clk);
        end
        chk("stream_drained", 64'(out_valid), 64'd0);

        // Backpressure: tags 3,4 accepted, 5 refused while full.
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 1'b0, 1'b0, 33'd3, 5'd3);
        @(negedge clk);
        chk("bp_ready_after1", 64'(in_ready), 64'd1);
        drive(1'b1, 3'd1, 1'b0, 1'b0, 33'd4, 5'd4);
        @(negedge clk);
        chk("bp_ready_full", 64'(in_ready), 64'd0);
        drive(1'b1, 3'd1, 1'b0, 1'b0, 33'd5, 5'd5);
        @(negedge clk);
        chk("bp_still_full", 64'(in_ready), 64'd0);
        chk("bp_head3", 64'(out_tag), 64'd3);
        idle();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_after_pop", 64'(in_ready), 64'd1);
        chk("bp_head4_valid", 64'(out_valid), 64'd1);
        chk("bp_head4", 64'(out_tag), 64'd4);
        @(negedge clk);
        chk("bp_no_tag5", 64'(out_valid), 64'd0);

        // Flush at full with a push in the same cycle.
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 1'b0, 1'b0, 33'd7, 5'd7);
        @(negedge clk);
        drive(1'b1, 3'd1, 1'b0, 1'b0, 33'd8, 5'd8);
        @(negedge clk);
        chk("fl_full", 64'(in_ready), 64'd0);
        flush = 1'b1;
        drive(1'b1, 3'd1, 1'b0, 1'b0, 33'd9, 5'd9);
        @(negedge clk);
        flush = 1'b0;
        idle();
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        chk("fl_no_tag9", 64'(out_valid), 64'd0);

        // New traffic after flush starts from a clean head.
        out_ready = 1'b1;
        drive(1'b1, 3'd2, 1'b0, 1'b0, 33'd11, 5'd11);
        @(negedge clk);
        idle();
        chk("fl_resume_tag", 64'(out_tag), 64'd11);
        @(negedge clk);

        // Reset mid-fill: nothing survives.
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 1'b0, 1'b0, 33'd12, 5'd12);
        @(negedge clk);
        chk("mr_filled", 64'(out_valid), 64'd1);
        resetn = 1'b0;
        #1;
        chk("mr_valid_immediate", 64'(out_valid), 64'd0);
        chk("mr_tag_cleared", 64'(out_tag), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        idle();
        @(negedge clk);
        chk("mr_empty", 64'(out_valid), 64'd0);
        chk("mr_in_ready", 64'(in_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
